// File: rtl/phase_seq_pkg.sv
// Shared types for the phase sequencer: FSM state encoding and the named phase indices.
package phase_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      ERROR = 2'd2
   } state_t;

   localparam int PH_FETCH   = 0;
   localparam int PH_DECODE  = 1;
   localparam int PH_EXECUTE = 2;

endpackage

// File: rtl/phase_watchdog.sv
// Dwell counter for the current phase; flags expiry on the cycle the count would reach TIMEOUT-1.
module phase_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   localparam int DW = $clog2(TIMEOUT);
   localparam logic [DW-1:0] EXP_AT = DW'(TIMEOUT - 2);

   logic [DW-1:0] dwell;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell <= '0;
      end else if (clr) begin
         dwell <= '0;
      end else if (inc) begin
         dwell <= dwell + DW'(1);
      end
   end

   // expire fires on the waiting cycle whose increment lands on TIMEOUT-1
   assign expire = inc & (dwell == EXP_AT);

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase ring with start/halt, stall, ready handshake, watchdog and retire counter.
// Optional single-step control is compiled in with PHASE_SEQ_STEP_EN.
module phase_sequencer
   import phase_seq_pkg::*;
#(
   parameter int NUM_PHASES = 3,
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          halt_req,
   input  logic                          stall,
   input  logic                          phase_ready,
   input  logic                          err_clr,
`ifdef PHASE_SEQ_STEP_EN
   input  logic                          step_mode,
   input  logic                          step,
`endif
   output logic [NUM_PHASES-1:0]         phase_oh,
   output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
   output logic                          wrap,
   output logic [CNT_W-1:0]              retire_cnt,
   output logic                          busy,
   output logic                          err,
   output logic [1:0]                    state_dbg
);

   localparam int IW = $clog2(NUM_PHASES);
   localparam logic [IW-1:0]         LAST = IW'(NUM_PHASES - 1);
   localparam logic [NUM_PHASES-1:0] OH0  = NUM_PHASES'(1);

   // Handshake: a phase completes on a cycle where phase_ready is high and the
   // sequencer is not stalled (nor waiting for a step); stall always wins.

   state_t                state_q, state_n;
   logic [IW-1:0]         idx_q, idx_n;
   logic [NUM_PHASES-1:0] oh_q, oh_n;
   logic                  wrap_q, wrap_n;
   logic [CNT_W-1:0]      cnt_q, cnt_n;
   logic                  halt_q, halt_n;

   logic step_wait;
   logic advance;
   logic wd_clr;
   logic wd_inc;
   logic wd_expire;

`ifdef PHASE_SEQ_STEP_EN
   assign step_wait = step_mode & ~step;
`else
   assign step_wait = 1'b0;
`endif

   assign advance = (state_q == RUN) & phase_ready & ~stall & ~step_wait;
   assign wd_inc  = (state_q == RUN) & ~phase_ready & ~stall & ~step_wait;
   assign wd_clr  = (state_q != RUN) | advance;

   phase_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (wd_clr),
      .inc    (wd_inc),
      .expire (wd_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         oh_q    <= '0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         oh_q    <= oh_n;
         wrap_q  <= wrap_n;
         cnt_q   <= cnt_n;
         halt_q  <= halt_n;
      end
   end

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      oh_n    = oh_q;
      wrap_n  = 1'b0;
      cnt_n   = cnt_q;
      halt_n  = halt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               idx_n   = '0;
               oh_n    = OH0;
               halt_n  = 1'b0;
            end
         end
         RUN: begin
            if (halt_req) halt_n = 1'b1;
            if (advance) begin
               if (idx_q == LAST) begin
                  wrap_n = 1'b1;
                  cnt_n  = cnt_q + CNT_W'(1);
                  idx_n  = '0;
                  oh_n   = OH0;
                  // a halt raised on this very cycle still ends the pass here
                  if (halt_q | halt_req) begin
                     state_n = IDLE;
                     oh_n    = '0;
                     halt_n  = 1'b0;
                  end
               end else begin
                  idx_n = idx_q + IW'(1);
                  oh_n  = {oh_q[NUM_PHASES-2:0], 1'b0};
               end
            end else if (wd_expire) begin
               state_n = ERROR;
               oh_n    = '0;
               halt_n  = 1'b0;
            end
         end
         ERROR: begin
            if (err_clr) begin
               state_n = IDLE;
               idx_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            idx_n   = '0;
            oh_n    = '0;
            halt_n  = 1'b0;
         end
      endcase
   end

   assign phase_oh   = oh_q;
   assign phase_idx  = idx_q;
   assign wrap       = wrap_q;
   assign retire_cnt = cnt_q;
   assign busy       = (state_q == RUN);
   assign err        = (state_q == ERROR);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default 3-phase instance plus a 5-phase, 2-bit-counter instance.
module tb_phase_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, halt_req = 1'b0, stall = 1'b0, phase_ready = 1'b0, err_clr = 1'b0;
   logic start5 = 1'b0, ready5 = 1'b0;

   logic [2:0] phase_oh;
   logic [1:0] phase_idx;
   logic       wrap, busy, err;
   logic [7:0] retire_cnt;
   logic [1:0] state_dbg;

   logic [4:0] oh5;
   logic [2:0] idx5;
   logic       wrap5, busy5, err5;
   logic [1:0] cnt5;
   logic [1:0] state_dbg5;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   phase_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .stall(stall),
      .phase_ready(phase_ready), .err_clr(err_clr),
`ifdef PHASE_SEQ_STEP_EN
      .step_mode(1'b0), .step(1'b0),
`endif
      .phase_oh(phase_oh), .phase_idx(phase_idx), .wrap(wrap), .retire_cnt(retire_cnt),
      .busy(busy), .err(err), .state_dbg(state_dbg)
   );

   phase_sequencer #(.NUM_PHASES(5), .CNT_W(2), .TIMEOUT(16)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .halt_req(1'b0), .stall(1'b0),
      .phase_ready(ready5), .err_clr(1'b0),
`ifdef PHASE_SEQ_STEP_EN
      .step_mode(1'b0), .step(1'b0),
`endif
      .phase_oh(oh5), .phase_idx(idx5), .wrap(wrap5), .retire_cnt(cnt5),
      .busy(busy5), .err(err5), .state_dbg(state_dbg5)
   );

   // inputs are changed and outputs sampled 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (phase_oh !== 3'b000) begin failures++; $display("FAIL reset_oh got=%b exp=000", phase_oh); end
      checks++; if (phase_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", phase_idx); end
      checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
      checks++; if (retire_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", retire_cnt); end
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, err); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ring();
      logic [2:0] e;
      start = 1'b1; phase_ready = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (phase_oh !== 3'b001 || busy !== 1'b1) begin failures++; $display("FAIL ring_start got=%b busy=%b exp=001 busy=1", phase_oh, busy); end
      for (int k = 1; k <= 6; k++) begin
         tick();
         e = 3'b001 << (k % 3);
         checks++; if (phase_oh !== e) begin failures++; $display("FAIL ring_oh k=%0d got=%b exp=%b", k, phase_oh, e); end
         checks++; if (wrap !== ((k % 3) == 0)) begin failures++; $display("FAIL ring_wrap k=%0d got=%b", k, wrap); end
         checks++; if (retire_cnt !== 8'(k / 3)) begin failures++; $display("FAIL ring_cnt k=%0d got=%0d exp=%0d", k, retire_cnt, k / 3); end
      end
   endtask

   task automatic test_stall();
      tick();
      checks++; if (phase_oh !== 3'b010) begin failures++; $display("FAIL stall_pre got=%b exp=010", phase_oh); end
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (phase_oh !== 3'b010 || err !== 1'b0) begin failures++; $display("FAIL stall_hold k=%0d got=%b err=%b exp=010 err=0", k, phase_oh, err); end
      end
      stall = 1'b0;
      tick();
      checks++; if (phase_oh !== 3'b100 || phase_idx !== 2'd2) begin failures++; $display("FAIL stall_release got=%b idx=%0d exp=100 idx=2", phase_oh, phase_idx); end
      tick();
      checks++; if (phase_oh !== 3'b001 || wrap !== 1'b1 || retire_cnt !== 8'd3) begin failures++; $display("FAIL stall_wrap got=%b wrap=%b cnt=%0d exp=001 1 3", phase_oh, wrap, retire_cnt); end
   endtask

   task automatic test_halt();
      tick();
      checks++; if (phase_oh !== 3'b010) begin failures++; $display("FAIL halt_pre got=%b exp=010", phase_oh); end
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      checks++; if (phase_oh !== 3'b100 || busy !== 1'b1) begin failures++; $display("FAIL halt_exec got=%b busy=%b exp=100 busy=1", phase_oh, busy); end
      tick();
      checks++; if (phase_oh !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL halt_idle got=%b busy=%b exp=000 busy=0", phase_oh, busy); end
      checks++; if (wrap !== 1'b1 || retire_cnt !== 8'd4) begin failures++; $display("FAIL halt_wrap got=%b cnt=%0d exp=1 4", wrap, retire_cnt); end
      tick();
      checks++; if (phase_oh !== 3'b000 || wrap !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL halt_stays got=%b wrap=%b busy=%b exp=000 0 0", phase_oh, wrap, busy); end
   endtask

   task automatic test_watchdog();
      phase_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 14; k++) tick();
      checks++; if (err !== 1'b0 || phase_oh !== 3'b001) begin failures++; $display("FAIL wd_before got err=%b oh=%b exp err=0 oh=001", err, phase_oh); end
      tick();
      checks++; if (err !== 1'b1 || phase_oh !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL wd_expire got err=%b oh=%b busy=%b exp 1 000 0", err, phase_oh, busy); end
      start = 1'b1; phase_ready = 1'b1;
      tick();
      tick();
      start = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL wd_sticky got err=%b exp=1", err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++; if (err !== 1'b0 || busy !== 1'b0 || phase_idx !== 2'd0) begin failures++; $display("FAIL wd_clear got err=%b busy=%b idx=%0d exp 0 0 0", err, busy, phase_idx); end
   endtask

   task automatic test_watchdog_stall();
      start = 1'b1; phase_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      phase_ready = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      stall = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      stall = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      checks++; if (err !== 1'b0 || phase_oh !== 3'b010) begin failures++; $display("FAIL wdst_before got err=%b oh=%b exp 0 010", err, phase_oh); end
      tick();
      checks++; if (err !== 1'b1 || phase_idx !== 2'd1) begin failures++; $display("FAIL wdst_expire got err=%b idx=%0d exp 1 1", err, phase_idx); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++; if (err !== 1'b0 || phase_idx !== 2'd0) begin failures++; $display("FAIL wdst_clear got err=%b idx=%0d exp 0 0", err, phase_idx); end
   endtask

   task automatic test_async_reset();
      start = 1'b1; phase_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      checks++; if (phase_oh !== 3'b100 || retire_cnt !== 8'd4) begin failures++; $display("FAIL arst_pre got=%b cnt=%0d exp=100 4", phase_oh, retire_cnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (phase_oh !== 3'b000 || retire_cnt !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL arst_now got=%b cnt=%0d busy=%b exp 000 0 0", phase_oh, retire_cnt, busy); end
      tick();
      rst_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0; phase_ready = 1'b0;
      checks++; if (phase_oh !== 3'b001 || retire_cnt !== 8'd0) begin failures++; $display("FAIL arst_restart got=%b cnt=%0d exp=001 0", phase_oh, retire_cnt); end
   endtask

   task automatic test_five_phase();
      logic [4:0] e;
      logic [1:0] c;
      start5 = 1'b1; ready5 = 1'b1;
      tick();
      start5 = 1'b0;
      checks++; if (oh5 !== 5'b00001) begin failures++; $display("FAIL p5_start got=%b exp=00001", oh5); end
      for (int k = 1; k <= 25; k++) begin
         tick();
         e = 5'b00001 << (k % 5);
         c = 2'((k / 5) % 4);
         checks++; if (oh5 !== e || idx5 !== 3'(k % 5)) begin failures++; $display("FAIL p5_oh k=%0d got=%b idx=%0d exp=%b", k, oh5, idx5, e); end
         if ((k % 5) == 0) begin
            checks++; if (wrap5 !== 1'b1 || cnt5 !== c) begin failures++; $display("FAIL p5_cnt k=%0d wrap=%b got=%0d exp=%0d", k, wrap5, cnt5, c); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ring();
      test_stall();
      test_halt();
      test_watchdog();
      test_watchdog_stall();
      test_async_reset();
      test_five_phase();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
